// File: rtl/bsg_arb_pkg.sv
// -----------------------------------------------------------------------------
// bsg_arb_pkg
// Shared definitions for the packet-granular round-robin burst-lock arbiter.
//   arb_state_e   : arbiter FSM states (idle / locked on one source)
//   arb_tag_width : width of a requester index, $clog2(n), at least one bit
// No ports (package).
// -----------------------------------------------------------------------------
package bsg_arb_pkg;

    typedef enum logic [0:0] {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } arb_state_e;

    function automatic int unsigned arb_tag_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/bsg_rr_priority_select.sv
// -----------------------------------------------------------------------------
// bsg_rr_priority_select
// Combinational round-robin pick. Priority starts one position after the
// previous winner (wrapping at inputs_p). Built as rotate, fixed-priority
// encode (lowest index wins), then unrotate.
// Ports:
//   v_i        in   inputs_p     request vector
//   last_i     in   tag_width_p  index of the previous winner
//   one_hot_o  out  inputs_p     one-hot winner, all zero when no request
//   tag_o      out  tag_width_p  index of the winner, zero when no request
// -----------------------------------------------------------------------------
module bsg_rr_priority_select
    import bsg_arb_pkg::*;
#(
    parameter int unsigned inputs_p    = 4,
    parameter int unsigned tag_width_p = arb_tag_width(inputs_p)
) (
    input  logic [inputs_p-1:0]    v_i,
    input  logic [tag_width_p-1:0] last_i,
    output logic [inputs_p-1:0]    one_hot_o,
    output logic [tag_width_p-1:0] tag_o
);

    // Modulo-inputs_p addition, so non-power-of-two requester counts wrap correctly.
    function automatic logic [tag_width_p-1:0] wrap_add(input int unsigned a, input int unsigned b);
        int unsigned s;
        s = (a + b) % inputs_p;
        return s[tag_width_p-1:0];
    endfunction

    logic [tag_width_p-1:0] start_s;
    logic [inputs_p-1:0]    rot_s;
    logic [tag_width_p-1:0] win_rot_s;
    logic                   any_s;

    // Highest priority goes to the requester just after the previous winner.
    always_comb begin
        start_s = wrap_add(32'(last_i), 32'd1);
    end

    // Rotate so the highest-priority requester lands on bit 0.
    always_comb begin
        rot_s = '0;
        for (int unsigned k = 0; k < inputs_p; k++) begin
            rot_s[k] = v_i[wrap_add(k, 32'(start_s))];
        end
    end

    // Fixed-priority encode of the rotated vector: lowest set bit wins.
    always_comb begin
        win_rot_s = '0;
        for (int k = int'(inputs_p) - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                win_rot_s = tag_width_p'(k);
            end else begin
                win_rot_s = win_rot_s;
            end
        end
    end

    // Unrotate back to a requester index and decode to one-hot.
    always_comb begin
        any_s     = |v_i;
        tag_o     = '0;
        one_hot_o = '0;
        if (any_s) begin
            tag_o            = wrap_add(32'(win_rot_s), 32'(start_s));
            one_hot_o[tag_o] = 1'b1;
        end else begin
            tag_o     = '0;
            one_hot_o = '0;
        end
    end

endmodule

// File: rtl/bsg_rr_burst_lock_arb.sv
// -----------------------------------------------------------------------------
// bsg_rr_burst_lock_arb
// Round-robin arbiter sharing one downstream channel between inputs_p
// requesters at packet granularity. The grant is held from a packet's header
// beat through its last beat so bursts never interleave. Valid/yumi
// handshakes on both sides; zero-cycle latency from v_i to v_o.
//
// Optional feature, macro BSG_RR_ARB_WATCHDOG_EN: a starvation watchdog that
// releases a lock whose source stays silent for timeout_p cycles and raises
// a sticky error_o. Without the macro the lock is held indefinitely and
// error_o is tied low.
//
// Ports:
//   clk_i          in   1                      clock
//   reset_i        in   1                      synchronous active-high reset
//   v_i            in   inputs_p               requester has a beat
//   len_i          in   inputs_p*len_width_p   per-requester beats-1 (header only)
//   yumi_o         out  inputs_p               beat from requester i consumed
//   v_o            out  1                      beat presented downstream
//   sel_one_hot_o  out  inputs_p               one-hot data mux select
//   tag_o          out  $clog2(inputs_p)       selected requester index
//   last_o         out  1                      presented beat ends its packet
//   yumi_i         in   1                      downstream consumes the beat
//   error_o        out  1                      sticky watchdog error
// -----------------------------------------------------------------------------
module bsg_rr_burst_lock_arb
    import bsg_arb_pkg::*;
#(
    parameter  int unsigned inputs_p     = 4,
    parameter  int unsigned len_width_p  = 4,
    parameter  int unsigned timeout_p    = 16,
    localparam int unsigned tag_width_lp = arb_tag_width(inputs_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [inputs_p-1:0]             v_i,
    input  logic [inputs_p*len_width_p-1:0] len_i,
    output logic [inputs_p-1:0]             yumi_o,
    output logic                            v_o,
    output logic [inputs_p-1:0]             sel_one_hot_o,
    output logic [tag_width_lp-1:0]         tag_o,
    output logic                            last_o,
    input  logic                            yumi_i,
    output logic                            error_o
);

    arb_state_e              state_q, state_d;
    logic [len_width_p-1:0]  cnt_q, cnt_d;
    logic [tag_width_lp-1:0] lock_q, lock_d;
    logic [tag_width_lp-1:0] last_q, last_d;

    logic [len_width_p-1:0]  len_a_s [inputs_p];
    logic [inputs_p-1:0]     pick_oh_s;
    logic [tag_width_lp-1:0] pick_tag_s;
    logic [len_width_p-1:0]  pick_len_s;
    logic                    lock_v_s;
    logic                    v_s;
    logic                    last_s;
    logic                    fire_s;
    logic [inputs_p-1:0]     sel_s;
    logic [tag_width_lp-1:0] tag_s;
    logic                    trip_s;

    bsg_rr_priority_select #(
        .inputs_p    (inputs_p),
        .tag_width_p (tag_width_lp)
    ) pick (
        .v_i       (v_i),
        .last_i    (last_q),
        .one_hot_o (pick_oh_s),
        .tag_o     (pick_tag_s)
    );

    // Split the flat length bus into one field per requester.
    always_comb begin
        for (int unsigned i = 0; i < inputs_p; i++) begin
            len_a_s[i] = len_i[i*len_width_p +: len_width_p];
        end
    end

    // Length of the idle-state winner and validity of the locked source.
    always_comb begin
        pick_len_s = len_a_s[pick_tag_s];
        lock_v_s   = v_i[lock_q];
    end

    // Downstream presentation: idle follows the round-robin pick, locked is
    // pinned to the owner even while it bubbles; everything quiet in reset.
    always_comb begin
        v_s    = 1'b0;
        sel_s  = '0;
        tag_s  = '0;
        last_s = 1'b0;
        if (reset_i) begin
            v_s    = 1'b0;
            sel_s  = '0;
            tag_s  = '0;
            last_s = 1'b0;
        end else begin
            case (state_q)
                e_idle: begin
                    v_s    = |v_i;
                    sel_s  = pick_oh_s;
                    tag_s  = pick_tag_s;
                    last_s = (|v_i) && (pick_len_s == '0);
                end
                e_locked: begin
                    v_s           = lock_v_s;
                    sel_s[lock_q] = 1'b1;
                    tag_s         = lock_q;
                    last_s        = lock_v_s && (cnt_q == len_width_p'(1));
                end
                default: begin
                    v_s    = 1'b0;
                    sel_s  = '0;
                    tag_s  = '0;
                    last_s = 1'b0;
                end
            endcase
        end
    end

    // A yumi_i with nothing presented is ignored, so fire needs v_s.
    assign fire_s        = v_s & yumi_i;
    assign v_o           = v_s;
    assign sel_one_hot_o = sel_s;
    assign tag_o         = tag_s;
    assign last_o        = last_s;
    assign yumi_o        = sel_s & {inputs_p{fire_s}};

`ifdef BSG_RR_ARB_WATCHDOG_EN
    localparam int unsigned starve_width_lp = arb_tag_width(timeout_p) + 32'd1;
    localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(timeout_p - 32'd1);

    logic [starve_width_lp-1:0] starve_q, starve_d;
    logic                       error_q, error_d;

    // Count consecutive silent cycles of the locked source; trip on the last one.
    always_comb begin
        starve_d = starve_q;
        error_d  = error_q;
        trip_s   = 1'b0;
        if ((state_q == e_locked) && !lock_v_s) begin
            if (starve_q == starve_max_lp) begin
                trip_s   = 1'b1;
                error_d  = 1'b1;
                starve_d = '0;
            end else begin
                starve_d = starve_q + starve_width_lp'(1);
            end
        end else begin
            starve_d = '0;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= '0;
            error_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            error_q  <= error_d;
        end
    end

    assign error_o = error_q;
`else
    localparam int unsigned unused_timeout_lp = timeout_p;

    assign trip_s  = 1'b0;
    assign error_o = 1'b0;
`endif

    // FSM next state: header beats open a lock, the final beat releases it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        last_d  = last_q;
        case (state_q)
            e_idle: begin
                if (fire_s) begin
                    if (pick_len_s == '0) begin
                        last_d = pick_tag_s;
                    end else begin
                        lock_d  = pick_tag_s;
                        cnt_d   = pick_len_s;
                        state_d = e_locked;
                    end
                end else begin
                    state_d = e_idle;
                end
            end
            e_locked: begin
                if (trip_s) begin
                    // Abandon the rest of the packet.
                    last_d  = lock_q;
                    cnt_d   = '0;
                    state_d = e_idle;
                end else if (fire_s) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        last_d  = lock_q;
                        state_d = e_idle;
                    end else begin
                        state_d = e_locked;
                    end
                end else begin
                    state_d = e_locked;
                end
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            cnt_q   <= '0;
            lock_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
        end
    end

endmodule
